control_unit: RTL
=================

# control_unit

Hardwired sequencer for the 8-bit datapath: register file, address register file, IR register and ALU. Each instruction runs a fixed 3-cycle fetch-low/fetch-high/execute sequence, and the unit drives every datapath control input. It is the initiator on the control interface that the datapath blocks answer: it reads the 16-bit IR and the ALU flags and issues FunSel/RSel/select words.

## Interface
- No parameters. Datapath width is fixed at 8 bits and instruction width at 16 bits.
- clock  in  1  single system clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- ir  in  16  IROut
  - [15:12] opcode
  - [11:10] Rd
  - [9:8] Rs
  - [7:0] imm
- flags  in  4  ALU flag register, {Z,C,N,O}
- ir_e, ir_l_h  out  1 each  IR enable; half select (0 = low byte, 1 = high byte)
- ir_funsel  out  2  IR FunSel
- arf_funsel, arf_rsel  out  2, 4  ARF FunSel and RSel; RSel bits are {PC,AR,SP,PCPast}
- arf_outb_sel  out  2  memory address source; 11 = PC
- rf_funsel, rf_rsel, rf_tsel  out  2, 4, 4  RF FunSel, RSel and TSel; RSel bit3 = R1 … bit0 = R4
- rf_o1sel, rf_o2sel  out  3 each  RF output selects; Rn = {1'b1, n-1}
- alu_funsel  out  4  ALU function
- rf_in_sel  out  2  RF input mux: 00 = ALU, 01 = imm, 10 = memory
- arf_in_sel  out  1  ARF input mux: 0 = ALU, 1 = imm
- mem_rd  out  1  memory read strobe
- halted  out  1  high in HALT state

## Operation
- FunSel encoding for all registers: 00 clear, 01 load, 10 decrement, 11 increment.
- Any output not listed for a state is 0 in that state, so all enables are off.
- States: INIT, FETCH_L, FETCH_H, EXEC, HALT.
- INIT (1 cycle)
  - arf_rsel=1111, arf_funsel=00
  - rf_rsel=1111, rf_tsel=1111, rf_funsel=00
  - Next state: FETCH_L.
- FETCH_L
  - mem_rd=1, arf_outb_sel=11
  - ir_e=1, ir_funsel=01, ir_l_h=0
  - arf_rsel=1000, arf_funsel=11 (PC+1)
  - Next state: FETCH_H.
- FETCH_H: same as FETCH_L but ir_l_h=1. Next state: EXEC.
- EXEC, decoded from ir:
  - 0x0–0x7, ALU ops with A=Rd (o1sel), B=Rs (o2sel), result to Rd (rf_in_sel=00, rf_funsel=01): ADD 0100, SUB 0101, AND 0111, OR 1000, XOR 1010, NOT 0010 (~A), LSL 1011, LSR 1100.
  - 0x8 LDI: Rd ← imm (rf_in_sel=01, rf_funsel=01).
  - 0x9 INC / 0xA DEC: Rd, rf_funsel 11 / 10.
  - 0xB BRA: PC ← imm (arf_rsel=1000, arf_funsel=01, arf_in_sel=1).
  - 0xC BEQ: as BRA when Z=1, else nothing.
  - 0xD BNE: as BRA when Z=0, else nothing.
  - 0xE NOP: nothing.
  - 0xF HLT: next state HALT.
  - Every other opcode: next state FETCH_L.
- Rd one-hot: rf_rsel = 4'b1000 >> Rd.
- Rs select: o2sel = {1'b1, Rs}. Rd select: o1sel = {1'b1, Rd}.
- HALT: all enables 0, halted=1. Exit only through reset.

## Timing
- State register updates on the rising clock edge.
- Outputs are combinational from the current state and ir (Moore on state, decoded on ir). The datapath samples them at the next edge.
- Instruction latency: exactly 3 cycles (FETCH_L, FETCH_H, EXEC).
- Branch condition uses flags as sampled during EXEC, i.e. the flags produced by the previous instruction.
- Reset behaviour:
  - While reset_n=0, all outputs are forced to 0 (halted=0) regardless of state.
  - An edge with reset_n=0 sets state to INIT.
  - Reset asserted in any state, including mid-fetch or EXEC, aborts the instruction; no partial register writes happen after that edge.
- Reset release: INIT occupies the first cycle after reset_n goes high, and the first FETCH_L follows it.
- PC wrap-around (FF→00) is the ARF's behaviour and needs no special handling here.

## Configuration
- CU_BRANCH_EN defined: BRA, BEQ and BNE behave as specified above.
- CU_BRANCH_EN undefined:
  - Opcodes 0xB–0xD decode as NOP; arf_in_sel is tied to 0.
  - The flags input is unused.
  - Sequencing is otherwise identical.

## Structure
- Package cu_pkg holds:
  - state enum
  - opcode constants
  - FunSel constants (CLR, LD, DEC, INC)
  - ALU FunSel constants
  - ARF and RF RSel one-hot constants
  - mux-select constants
- Sub-module cu_decode: purely combinational; maps {state, ir, flags} to the control word.
- control_unit holds only the state register and next-state logic.

## Test plan
- Reset then release → one INIT cycle: arf_rsel=1111, rf_rsel=1111, funsel=00. Then FETCH_L: ir_e=1, ir_l_h=0, PC increment.
- ir=16'h8A37 (LDI R3, 0x37) in EXEC → rf_rsel=0010, rf_in_sel=01, rf_funsel=01.
- ir=16'h0400 (ADD R2, R1) → o1sel=101, o2sel=100, alu_funsel=0100, rf_rsel=0100.
- ir=16'hC042 (BEQ 0x42):
  - flags=1000 → arf_rsel=1000, arf_funsel=01, arf_in_sel=1.
  - flags=0000 → all enables 0.
  - With CU_BRANCH_EN undefined → all enables 0 for both flag values.
- ir=16'hF000 (HLT) → halted=1 and all enables 0 for 10 further cycles; then reset_n=0 for one edge → INIT.
- reset_n pulsed low during FETCH_H → outputs 0 that cycle, IR not loaded at that edge, next state INIT.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the hardwired control unit.
// Holds the sequencer state enum, opcode map, FunSel/ALU/select encodings,
// the packed control word driven onto the datapath, and small decode helpers.
package cu_pkg;

    localparam int unsigned IR_W     = 16;
    localparam int unsigned IMM_W    = 8;   // datapath width, carried in the IR low byte
    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned FUNSEL_W = 2;
    localparam int unsigned RSEL_W   = 4;
    localparam int unsigned OSEL_W   = 3;
    localparam int unsigned ALU_W    = 4;
    localparam int unsigned MUX_W    = 2;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Opcodes (IR[15:12]); 0x0-0x7 are ALU operations.
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_BRA = 4'hB;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_BNE = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Register FunSel encoding shared by IR, ARF and RF.
    localparam logic [FUNSEL_W-1:0] FS_CLR = 2'b00;
    localparam logic [FUNSEL_W-1:0] FS_LD  = 2'b01;
    localparam logic [FUNSEL_W-1:0] FS_DEC = 2'b10;
    localparam logic [FUNSEL_W-1:0] FS_INC = 2'b11;

    // ALU function codes.
    localparam logic [ALU_W-1:0] ALU_NOT = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_LSL = 4'b1011;
    localparam logic [ALU_W-1:0] ALU_LSR = 4'b1100;

    // One-hot register selects.
    localparam logic [RSEL_W-1:0] ARF_RSEL_PC  = 4'b1000;
    localparam logic [RSEL_W-1:0] ARF_RSEL_ALL = 4'b1111;
    localparam logic [RSEL_W-1:0] RF_RSEL_R1   = 4'b1000;
    localparam logic [RSEL_W-1:0] RF_RSEL_ALL  = 4'b1111;

    // Mux selects.
    localparam logic [MUX_W-1:0] OUTB_PC    = 2'b11;
    localparam logic [MUX_W-1:0] RF_IN_ALU  = 2'b00;
    localparam logic [MUX_W-1:0] RF_IN_IMM  = 2'b01;
    localparam logic             ARF_IN_IMM = 1'b1;
    localparam logic             IR_HALF_LO = 1'b0;
    localparam logic             IR_HALF_HI = 1'b1;

    // Bit position of Z in flags {Z,C,N,O}.
    localparam int unsigned FLAG_Z = 3;

    typedef struct packed {
        logic                ir_e;
        logic                ir_l_h;
        logic [FUNSEL_W-1:0] ir_funsel;
        logic [FUNSEL_W-1:0] arf_funsel;
        logic [RSEL_W-1:0]   arf_rsel;
        logic [MUX_W-1:0]    arf_outb_sel;
        logic [FUNSEL_W-1:0] rf_funsel;
        logic [RSEL_W-1:0]   rf_rsel;
        logic [RSEL_W-1:0]   rf_tsel;
        logic [OSEL_W-1:0]   rf_o1sel;
        logic [OSEL_W-1:0]   rf_o2sel;
        logic [ALU_W-1:0]    alu_funsel;
        logic [MUX_W-1:0]    rf_in_sel;
        logic                arf_in_sel;
        logic                mem_rd;
        logic                halted;
    } ctrl_word_t;

    // Rd index -> one-hot RF RSel (R1 is the MSB).
    function automatic logic [RSEL_W-1:0] rf_onehot(input logic [1:0] idx);
        return RF_RSEL_R1 >> idx;
    endfunction

    // Register index -> RF output select; Rn = {1'b1, n-1}.
    function automatic logic [OSEL_W-1:0] rf_osel(input logic [1:0] idx);
        return {1'b1, idx};
    endfunction

    // ALU opcode (0x0-0x7) -> ALU FunSel.
    function automatic logic [ALU_W-1:0] alu_code(input logic [2:0] op);
        logic [ALU_W-1:0] code;
        case (op)
            3'd0:    code = ALU_ADD;
            3'd1:    code = ALU_SUB;
            3'd2:    code = ALU_AND;
            3'd3:    code = ALU_OR;
            3'd4:    code = ALU_XOR;
            3'd5:    code = ALU_NOT;
            3'd6:    code = ALU_LSL;
            default: code = ALU_LSR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cu_if.sv
// Control interface between the sequencer (master) and the datapath (slave).
// Master reads ir/flags and drives every datapath control select.
interface cu_if;
    import cu_pkg::*;

    logic [IR_W-1:0]     ir;
    logic [FLAG_W-1:0]   flags;
    logic                ir_e;
    logic                ir_l_h;
    logic [FUNSEL_W-1:0] ir_funsel;
    logic [FUNSEL_W-1:0] arf_funsel;
    logic [RSEL_W-1:0]   arf_rsel;
    logic [MUX_W-1:0]    arf_outb_sel;
    logic [FUNSEL_W-1:0] rf_funsel;
    logic [RSEL_W-1:0]   rf_rsel;
    logic [RSEL_W-1:0]   rf_tsel;
    logic [OSEL_W-1:0]   rf_o1sel;
    logic [OSEL_W-1:0]   rf_o2sel;
    logic [ALU_W-1:0]    alu_funsel;
    logic [MUX_W-1:0]    rf_in_sel;
    logic                arf_in_sel;
    logic                mem_rd;
    logic                halted;

    modport master (
        input  ir, flags,
        output ir_e, ir_l_h, ir_funsel, arf_funsel, arf_rsel, arf_outb_sel,
               rf_funsel, rf_rsel, rf_tsel, rf_o1sel, rf_o2sel, alu_funsel,
               rf_in_sel, arf_in_sel, mem_rd, halted
    );

    modport slave (
        output ir, flags,
        input  ir_e, ir_l_h, ir_funsel, arf_funsel, arf_rsel, arf_outb_sel,
               rf_funsel, rf_rsel, rf_tsel, rf_o1sel, rf_o2sel, alu_funsel,
               rf_in_sel, arf_in_sel, mem_rd, halted
    );

endinterface

// File: rtl/cu_decode.sv
// Combinational control-word decoder: {state, ir, flags} -> datapath controls.
// Ports: state (sequencer state), ir (16-bit IROut), flags ({Z,C,N,O}),
//        ctrl (full control word).
// Build option: CU_BRANCH_EN enables BRA/BEQ/BNE; without it they decode as NOP
// and flags are ignored.
module cu_decode
    import cu_pkg::*;
(
    input  state_t            state,
    input  logic [IR_W-1:0]   ir,
    input  logic [FLAG_W-1:0] flags,
    output ctrl_word_t        ctrl
);

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       branch_taken;
    logic       unused_bits;

    assign op = ir[15:12];
    assign rd = ir[11:10];
    assign rs = ir[9:8];

    // The immediate is routed by the datapath muxes, never decoded here.
`ifdef CU_BRANCH_EN
    assign branch_taken = (op == OP_BRA)
                       || ((op == OP_BEQ) &&  flags[FLAG_Z])
                       || ((op == OP_BNE) && !flags[FLAG_Z]);
    assign unused_bits  = ^ir[IMM_W-1:0];
`else
    assign branch_taken = 1'b0;
    assign unused_bits  = ^{ir[IMM_W-1:0], flags};
`endif

    // Control word; everything not named for a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_INIT: begin
                ctrl.arf_rsel   = ARF_RSEL_ALL;
                ctrl.arf_funsel = FS_CLR;
                ctrl.rf_rsel    = RF_RSEL_ALL;
                ctrl.rf_tsel    = RF_RSEL_ALL;
                ctrl.rf_funsel  = FS_CLR;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                ctrl.mem_rd       = 1'b1;
                ctrl.arf_outb_sel = OUTB_PC;
                ctrl.ir_e         = 1'b1;
                ctrl.ir_funsel    = FS_LD;
                ctrl.ir_l_h       = (state == ST_FETCH_H) ? IR_HALF_HI : IR_HALF_LO;
                ctrl.arf_rsel     = ARF_RSEL_PC;
                ctrl.arf_funsel   = FS_INC;
            end
            ST_EXEC: begin
                if (!op[3]) begin
                    ctrl.alu_funsel = alu_code(op[2:0]);
                    ctrl.rf_o1sel   = rf_osel(rd);
                    ctrl.rf_o2sel   = rf_osel(rs);
                    ctrl.rf_rsel    = rf_onehot(rd);
                    ctrl.rf_funsel  = FS_LD;
                    ctrl.rf_in_sel  = RF_IN_ALU;
                end else begin
                    case (op)
                        OP_LDI: begin
                            ctrl.rf_rsel   = rf_onehot(rd);
                            ctrl.rf_funsel = FS_LD;
                            ctrl.rf_in_sel = RF_IN_IMM;
                        end
                        OP_INC: begin
                            ctrl.rf_rsel   = rf_onehot(rd);
                            ctrl.rf_funsel = FS_INC;
                        end
                        OP_DEC: begin
                            ctrl.rf_rsel   = rf_onehot(rd);
                            ctrl.rf_funsel = FS_DEC;
                        end
                        OP_BRA, OP_BEQ, OP_BNE: begin
                            if (branch_taken) begin
                                ctrl.arf_rsel   = ARF_RSEL_PC;
                                ctrl.arf_funsel = FS_LD;
                                ctrl.arf_in_sel = ARF_IN_IMM;
                            end
                        end
                        default: ;  // NOP, HLT: no datapath activity
                    endcase
                end
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired 3-cycle sequencer (FETCH_L, FETCH_H, EXEC) for the 8-bit datapath.
// Ports: clock, reset_n (synchronous, active-low), bus (cu_if.master: ir and
//        flags in, all datapath controls out; controls are combinational).
// Build option: CU_BRANCH_EN enables the BRA/BEQ/BNE instructions.
module control_unit
    import cu_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    cu_if.master  bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t dec_word;
    ctrl_word_t ctrl_c;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_FETCH_L;
            ST_FETCH_L: state_d = ST_FETCH_H;
            ST_FETCH_H: state_d = ST_EXEC;
            ST_EXEC:    state_d = (bus.ir[15:12] == OP_HLT) ? ST_HALT : ST_FETCH_L;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_INIT;
        endcase
    end

    cu_decode u_decode (
        .state (state_q),
        .ir    (bus.ir),
        .flags (bus.flags),
        .ctrl  (dec_word)
    );

    // Output logic; reset masks every control so no write lands on the reset edge.
    always_comb begin
        ctrl_c = '0;
        if (reset_n) begin
            ctrl_c = dec_word;
        end
    end

    assign bus.ir_e         = ctrl_c.ir_e;
    assign bus.ir_l_h       = ctrl_c.ir_l_h;
    assign bus.ir_funsel    = ctrl_c.ir_funsel;
    assign bus.arf_funsel   = ctrl_c.arf_funsel;
    assign bus.arf_rsel     = ctrl_c.arf_rsel;
    assign bus.arf_outb_sel = ctrl_c.arf_outb_sel;
    assign bus.rf_funsel    = ctrl_c.rf_funsel;
    assign bus.rf_rsel      = ctrl_c.rf_rsel;
    assign bus.rf_tsel      = ctrl_c.rf_tsel;
    assign bus.rf_o1sel     = ctrl_c.rf_o1sel;
    assign bus.rf_o2sel     = ctrl_c.rf_o2sel;
    assign bus.alu_funsel   = ctrl_c.alu_funsel;
    assign bus.rf_in_sel    = ctrl_c.rf_in_sel;
    assign bus.arf_in_sel   = ctrl_c.arf_in_sel;
    assign bus.mem_rd       = ctrl_c.mem_rd;
    assign bus.halted       = ctrl_c.halted;

endmodule
